// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - op encodings carried on the op bus
//   - FSM state encoding
//   - datapath width and iteration count
package mdu_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = 32;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/result bundle between the datapath and the
// multiply/divide unit.
//   master (datapath): drives start/op/busA/busB/hiWEn/loWEn/busW,
//                      reads hi/lo/busy/done
//   slave  (unit)    : the reverse
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] busA;
    logic [WIDTH-1:0] busB;
    logic             hiWEn;
    logic             loWEn;
    logic [WIDTH-1:0] busW;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, busA, busB, hiWEn, loWEn, busW,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, busA, busB, hiWEn, loWEn, busW,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: conditional two's-complement negation.
//   i_val : value (magnitude or raw operand)
//   i_neg : 1 = negate
//   o_val : i_neg ? -i_val : i_val
// Used both for operand magnitudes at issue and for the final sign
// correction of product/quotient/remainder. The magnitude of the most
// negative value is its own bit pattern, which is correct when read as
// an unsigned magnitude.
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);
    assign o_val = i_neg ? ((~i_val) + W'(1)) : i_val;
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-cycle multiply/divide with HI/LO registers.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of mul_div_unit_if
//              start/op/busA/busB  - operation request (sampled when idle)
//              hiWEn/loWEn/busW    - MTHI/MTLO writes (ignored when busy)
//              hi/lo               - result registers
//              busy                - operation in flight
//              done                - one-cycle pulse when HI/LO are written
// Timing: start edge E0, 32 CALC edges, FIX edge E33 writes HI/LO and
// raises done. Operands are latched as unsigned magnitudes; sign is
// restored in FIX.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    mul_div_unit_if.slave  bus
);
    import mdu_pkg::*;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;        // multiplicand, or dividend shifting into quotient
    logic [WIDTH-1:0]   r_b;        // multiplier or divisor
    logic [WIDTH-1:0]   r_rem;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_neg_q;    // negate product / quotient
    logic               r_neg_r;    // negate remainder (dividend sign)
    logic               r_is_div;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic               r_busy, r_done;

    logic               w_signed, w_is_div;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_fix_p;
    logic [WIDTH-1:0]   w_fix_q, w_fix_r;

    assign w_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign w_is_div = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);

    mdu_sign_fix #(.W(WIDTH)) u_abs_a (
        .i_val(bus.busA), .i_neg(w_signed & bus.busA[WIDTH-1]), .o_val(w_abs_a));
    mdu_sign_fix #(.W(WIDTH)) u_abs_b (
        .i_val(bus.busB), .i_neg(w_signed & bus.busB[WIDTH-1]), .o_val(w_abs_b));

    mdu_sign_fix #(.W(2*WIDTH)) u_fix_p (
        .i_val(r_acc), .i_neg(r_neg_q), .o_val(w_fix_p));
    mdu_sign_fix #(.W(WIDTH)) u_fix_q (
        .i_val(r_a),   .i_neg(r_neg_q), .o_val(w_fix_q));
    mdu_sign_fix #(.W(WIDTH)) u_fix_r (
        .i_val(r_rem), .i_neg(r_neg_r), .o_val(w_fix_r));

    // Shift-add: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_b[r_cnt] ? {1'b0, r_a} : '0);

    // Restoring step on the 33-bit shifted partial remainder; after the
    // conditional subtract it is below the divisor and fits in WIDTH bits.
    assign w_rem_sh = {r_rem, r_a[WIDTH-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_b});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_acc    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_is_div <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.hiWEn) r_hi <= bus.busW;
                    if (bus.loWEn) r_lo <= bus.busW;
                    if (bus.start) begin
                        r_a      <= w_abs_a;
                        r_b      <= w_abs_b;
                        r_neg_q  <= w_signed & (bus.busA[WIDTH-1] ^ bus.busB[WIDTH-1]);
                        r_neg_r  <= w_signed & bus.busA[WIDTH-1];
                        r_is_div <= w_is_div;
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_rem    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    if (r_is_div) begin
                        r_rem <= w_ge ? WIDTH'(w_rem_sh - {1'b0, r_b}) : w_rem_sh[WIDTH-1:0];
                        r_a   <= {r_a[WIDTH-2:0], w_ge};
                    end else begin
                        r_acc <= {w_sum, r_acc[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(ITER - 1)) r_state <= FIX;
                end
                FIX: begin
                    if (r_is_div) begin
                        // Divide by zero: quotient all ones; the remainder path
                        // already reproduces the dividend.
                        r_lo <= (r_b == '0) ? '1 : w_fix_q;
                        r_hi <= w_fix_r;
                    end else begin
                        {r_hi, r_lo} <= w_fix_p;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule
